// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared RC4 definitions used by the transmit (rc4_top) and
//                receive (rc4_decrypt_rx) engines. It holds the engine state
//                encoding, the S-box size, the byte type and the key-byte
//                select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    localparam int SBOX_SIZE     = 256;
    localparam int MAX_KEY_BYTES = 16;

    typedef logic [7:0] rc4_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_KSA      = 3'd2,
        ST_READY    = 3'd3,
        ST_PRGA_OUT = 3'd4
    } rc4_state_t;

    // Key byte n lives at key[8*n+7:8*n]. The caller zero-extends its key
    // to the maximum width so one helper serves every KEY_BYTES setting.
    function automatic rc4_byte_t key_byte(
        input logic [8*MAX_KEY_BYTES-1:0] key_vec,
        input logic [3:0]                 idx
    );
        return key_vec[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_sbox
//  Description : 256 x 8 RC4 state array built from registers.
//                Two combinational read ports. One write port, used for
//                initialisation. One swap port that exchanges two entries in
//                a single cycle. The write port has priority. A swap with
//                equal addresses leaves the array unchanged.
//  Ports       : clk                    - clock
//                wr_en/wr_addr/wr_data  - single-entry write
//                swap_en/swap_a/swap_b  - exchange S[swap_a] and S[swap_b]
//                rd_addr_a/rd_data_a    - read port A (combinational)
//                rd_addr_b/rd_data_b    - read port B (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic      clk,
    input  logic      wr_en,
    input  rc4_byte_t wr_addr,
    input  rc4_byte_t wr_data,
    input  logic      swap_en,
    input  rc4_byte_t swap_a,
    input  rc4_byte_t swap_b,
    input  rc4_byte_t rd_addr_a,
    output rc4_byte_t rd_data_a,
    input  rc4_byte_t rd_addr_b,
    output rc4_byte_t rd_data_b
);

    // Contents are undefined after reset; INIT always rewrites every entry.
    rc4_byte_t mem [SBOX_SIZE];

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end else if (swap_en && (swap_a != swap_b)) begin
            mem[swap_a] <= mem[swap_b];
            mem[swap_b] <= mem[swap_a];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rc4_decrypt_rx.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_decrypt_rx
//  Description : Receive-side RC4 engine. On start it latches the key and
//                runs INIT (256 cycles) and then KSA (256 cycles). After that
//                it XORs each accepted ciphertext byte with the next PRGA
//                keystream byte. Throughput is one byte every two cycles.
//                The output is a single-entry register with valid/ready
//                handshaking.
//  Ports       : clk, rst (async, active low)
//                start, key, key_ready        - re-key control
//                cipher_in/valid/ready        - ciphertext input stream
//                plain_out/valid/ready        - plaintext output stream
//                byte_count                   - bytes produced since start
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_decrypt_rx
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 1,
    parameter int CNT_W     = 16
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   key_ready,
    input  logic [7:0]             cipher_in,
    input  logic                   cipher_valid,
    output logic                   cipher_ready,
    output logic [7:0]             plain_out,
    output logic                   plain_valid,
    input  logic                   plain_ready,
    output logic [CNT_W-1:0]       byte_count
);

    rc4_state_t state;
    rc4_state_t state_next;

    rc4_byte_t  i;
    rc4_byte_t  j;
    rc4_byte_t  t;
    rc4_byte_t  cipher_reg;
    logic [3:0] kidx;
    logic [8*KEY_BYTES-1:0]     key_reg;
    logic [8*MAX_KEY_BYTES-1:0] key_ext;

    rc4_byte_t  rd_addr_a;
    rc4_byte_t  rd_data_a;
    rc4_byte_t  rd_addr_b;
    rc4_byte_t  rd_data_b;
    logic       sbox_wr_en;
    logic       sbox_swap_en;
    rc4_byte_t  sbox_swap_a;
    rc4_byte_t  sbox_swap_b;

    rc4_byte_t  i_inc;
    rc4_byte_t  j_ksa;
    rc4_byte_t  j_prga;
    rc4_byte_t  t_next;
    logic       out_space;
    logic       transfer;

    always_comb begin
        key_ext                  = '0;
        key_ext[8*KEY_BYTES-1:0] = key_reg;
    end

    // ------------------------------------------------------------------
    // S-box address and index arithmetic (all modulo 256)
    // ------------------------------------------------------------------
    assign i_inc     = i + 8'd1;
    // Port A: S[i] in INIT/KSA, S[i+1] in READY, S[t] in PRGA_OUT.
    assign rd_addr_a = (state == ST_READY)    ? i_inc :
                       (state == ST_PRGA_OUT) ? t     : i;
    assign j_ksa     = j + rd_data_a + key_byte(key_ext, kidx);
    assign j_prga    = j + rd_data_a;
    assign rd_addr_b = j_prga;
    // After the swap, S[i]+S[j] equals the pre-swap S[i']+S[j'], so t can be
    // taken in the accept cycle. That leaves PRGA_OUT with a single read, S[t].
    assign t_next    = rd_data_a + rd_data_b;

    assign out_space = !plain_valid || plain_ready;
    assign transfer  = cipher_valid && cipher_ready;

    rc4_sbox u_sbox (
        .clk       (clk),
        .wr_en     (sbox_wr_en),
        .wr_addr   (i),
        .wr_data   (i),
        .swap_en   (sbox_swap_en),
        .swap_a    (sbox_swap_a),
        .swap_b    (sbox_swap_b),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. start re-keys from any state.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_INIT;
        end else begin
            case (state)
                ST_IDLE:     state_next = ST_IDLE;
                ST_INIT:     if (i == 8'hFF) state_next = ST_KSA;
                ST_KSA:      if (i == 8'hFF) state_next = ST_READY;
                ST_READY:    if (transfer)   state_next = ST_PRGA_OUT;
                ST_PRGA_OUT: state_next = ST_READY;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and S-box control
    // ------------------------------------------------------------------
    always_comb begin
        cipher_ready = 1'b0;
        sbox_wr_en   = 1'b0;
        sbox_swap_en = 1'b0;
        sbox_swap_a  = i;
        sbox_swap_b  = j;
        case (state)
            ST_INIT: begin
                sbox_wr_en = 1'b1;
            end
            ST_KSA: begin
                sbox_swap_en = 1'b1;
                sbox_swap_b  = j_ksa;
            end
            ST_READY: begin
                cipher_ready = out_space && !start;
                sbox_swap_en = cipher_valid && out_space && !start;
                sbox_swap_a  = i_inc;
                sbox_swap_b  = j_prga;
            end
            default: begin
                cipher_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: indices, key register, output register, counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i           <= '0;
            j           <= '0;
            t           <= '0;
            kidx        <= '0;
            cipher_reg  <= '0;
            key_reg     <= '0;
            key_ready   <= 1'b0;
            plain_out   <= '0;
            plain_valid <= 1'b0;
            byte_count  <= '0;
        end else if (start) begin
            key_reg     <= key;
            i           <= '0;
            j           <= '0;
            kidx        <= '0;
            key_ready   <= 1'b0;
            plain_valid <= 1'b0;
            byte_count  <= '0;
        end else begin
            // Registered, so key_ready rises one edge after READY is entered.
            key_ready <= (state == ST_READY) || (state == ST_PRGA_OUT);

            if (plain_valid && plain_ready) begin
                plain_valid <= 1'b0;
            end

            case (state)
                ST_INIT: begin
                    i    <= i_inc;
                    j    <= '0;
                    kidx <= '0;
                end
                ST_KSA: begin
                    i    <= i_inc;
                    j    <= (i == 8'hFF) ? 8'h00 : j_ksa;
                    kidx <= (kidx == 4'(KEY_BYTES - 1)) ? 4'd0 : kidx + 4'd1;
                end
                ST_READY: begin
                    if (transfer) begin
                        i          <= i_inc;
                        j          <= j_prga;
                        t          <= t_next;
                        cipher_reg <= cipher_in;
                    end
                end
                ST_PRGA_OUT: begin
                    plain_out   <= cipher_reg ^ rd_data_a;
                    plain_valid <= 1'b1;
                    byte_count  <= byte_count + CNT_W'(1);
                end
                default: begin
                    i <= i;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_decrypt_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_decrypt_rx
//  Description : Self-checking bench for rc4_decrypt_rx. It drives one
//                3-byte-key instance and one 1-byte-key instance from shared
//                stimulus and compares them against a plain RC4 reference
//                model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_decrypt_rx;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        start        = 1'b0;
    logic [23:0] key_a        = '0;
    logic [7:0]  key_b        = '0;
    logic [7:0]  cipher_in    = '0;
    logic        cipher_valid = 1'b0;
    logic        plain_ready  = 1'b0;
    logic        sel_b        = 1'b0;

    logic        a_key_ready, a_cipher_ready, a_plain_valid;
    logic [7:0]  a_plain_out;
    logic [15:0] a_byte_count;
    logic        b_key_ready, b_cipher_ready, b_plain_valid;
    logic [7:0]  b_plain_out;
    logic [15:0] b_byte_count;

    logic        key_ready, cipher_ready, plain_valid;
    logic [7:0]  plain_out;
    logic [15:0] byte_count;

    assign key_ready    = sel_b ? b_key_ready    : a_key_ready;
    assign cipher_ready = sel_b ? b_cipher_ready : a_cipher_ready;
    assign plain_valid  = sel_b ? b_plain_valid  : a_plain_valid;
    assign plain_out    = sel_b ? b_plain_out    : a_plain_out;
    assign byte_count   = sel_b ? b_byte_count   : a_byte_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] ks [$];
    logic [7:0] cq [$];
    logic [7:0] eq [$];

    rc4_decrypt_rx #(.KEY_BYTES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .key(key_a), .key_ready(a_key_ready),
        .cipher_in(cipher_in), .cipher_valid(cipher_valid), .cipher_ready(a_cipher_ready),
        .plain_out(a_plain_out), .plain_valid(a_plain_valid), .plain_ready(plain_ready),
        .byte_count(a_byte_count)
    );

    rc4_decrypt_rx #(.KEY_BYTES(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .key(key_b), .key_ready(b_key_ready),
        .cipher_in(cipher_in), .cipher_valid(cipher_valid), .cipher_ready(b_cipher_ready),
        .plain_out(b_plain_out), .plain_valid(b_plain_valid), .plain_ready(plain_ready),
        .byte_count(b_byte_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference RC4: textbook KSA followed by n PRGA keystream bytes.
    task automatic gen_ks(input logic [127:0] kv, input int kb, input int n);
        int s [256];
        int ii, jj, tmp;
        for (int x = 0; x < 256; x++) s[x] = x;
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + s[x] + int'(kv[8*(x % kb) +: 8])) % 256;
            tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
        end
        ks.delete();
        ii = 0; jj = 0;
        for (int x = 0; x < n; x++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            ks.push_back(8'(s[(s[ii] + s[jj]) % 256]));
        end
    endtask

    task automatic do_start(input logic [23:0] ka, input logic [7:0] kb);
        @(negedge clk);
        key_a = ka; key_b = kb; start = 1'b1; cipher_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges from the start edge until key_ready is seen high.
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!key_ready && n < 700) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, 513);
    endtask

    // Sends cq, expects eq in order. Optional input gaps, one hold of
    // plain_ready after the first output, and a byte-rate check.
    task automatic stream(input int hold_len, input bit gaps, input bit rate_chk, input string tag);
        int sent = 0, got = 0, budget = 0, last = -1, hold = 0, hk = 0;
        int n = cq.size();
        while (got < n && budget < 4000) begin
            @(negedge clk);
            budget++;
            plain_ready = (hold == 0);
            if (sent < n && (!gaps || $urandom_range(3) != 0)) begin
                cipher_valid = 1'b1;
                cipher_in    = cq[sent];
            end else begin
                cipher_valid = 1'b0;
                cipher_in    = 8'($urandom);
            end
            #1;
            if (hold > 0) begin
                hk++;
                check({tag, "_hold_cipher_ready"}, cipher_ready, 0);
                if (hk >= 2) begin
                    check({tag, "_hold_valid"}, plain_valid, 1);
                    check({tag, "_hold_data"}, plain_out, eq[got]);
                end
                hold--;
            end
            if (plain_valid && plain_ready) begin
                check({tag, "_data"}, plain_out, eq[got]);
                got++;
                if (rate_chk && last >= 0) check({tag, "_rate"}, cyc - last, 2);
                last = cyc;
                if (got == 1) hold = hold_len;
            end
            if (cipher_valid && cipher_ready) sent++;
        end
        cipher_valid = 1'b0;
        check({tag, "_complete"}, got, n);
    endtask

    task automatic fill_random(input int n);
        logic [7:0] c;
        cq.delete(); eq.delete();
        for (int x = 0; x < n; x++) begin
            c = 8'($urandom);
            cq.push_back(c);
            eq.push_back(c ^ ks[x]);
        end
    endtask

    initial begin
        logic [23:0] rkey;
        logic [7:0]  c4;
        logic [7:0]  p [5];

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        check("rst_key_ready", key_ready, 0);
        check("rst_cipher_ready", cipher_ready, 0);
        check("rst_plain_valid", plain_valid, 0);
        check("rst_plain_out", plain_out, 0);
        check("rst_byte_count", byte_count, 0);
        rst = 1'b1;

        // ---------------- 1: key ready latency ----------------
        do_start(24'h0, 8'h0);
        wait_ready("t1_key_ready_latency");
        check("t1_cipher_ready", cipher_ready, 1);
        check("t1_plain_valid", plain_valid, 0);
        check("t1_byte_count", byte_count, 0);

        // ---------------- 2: known answer "Key"/"Plaintext" ----------------
        do_start(24'h79654B, 8'h0);
        wait_ready("t2_key_ready");
        cq = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        eq = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        stream(0, 1'b0, 1'b1, "t2");
        check("t2_byte_count", byte_count, 9);

        // ---------------- 3: round trip, 1-byte key A0 ----------------
        sel_b = 1'b1;
        do_start(24'h0, 8'hA0);
        wait_ready("t3_key_ready");
        gen_ks(128'hA0, 1, 5);
        p = '{8'h05, 8'h0A, 8'h14, 8'h1E, 8'h28};
        cq.delete(); eq.delete();
        for (int x = 0; x < 5; x++) begin
            cq.push_back(p[x] ^ ks[x]);
            eq.push_back(p[x]);
        end
        stream(0, 1'b1, 1'b0, "t3");
        check("t3_byte_count", byte_count, 5);
        sel_b = 1'b0;

        // ---------------- 4: back-pressure hold ----------------
        rkey = 24'($urandom);
        do_start(rkey, 8'h0);
        wait_ready("t4_key_ready");
        gen_ks(128'(rkey), 3, 12);
        fill_random(12);
        stream(10, 1'b0, 1'b0, "t4");
        check("t4_byte_count", byte_count, 12);

        // ---------------- 5: re-key mid-stream ----------------
        do_start(24'h79654B, 8'h0);
        wait_ready("t5_key_ready");
        gen_ks(128'h79654B, 3, 8);
        fill_random(3);
        stream(0, 1'b1, 1'b0, "t5a");
        @(negedge clk);
        plain_ready = 1'b0; cipher_valid = 1'b1; c4 = 8'($urandom); cipher_in = c4;
        #1 check("t5_accept4", cipher_ready, 1);
        @(negedge clk);
        cipher_valid = 1'b0;
        @(negedge clk);
        #1;
        check("t5_pending_valid", plain_valid, 1);
        check("t5_pending_data", plain_out, c4 ^ ks[3]);
        @(negedge clk);
        start = 1'b1; cipher_valid = 1'b1; cipher_in = 8'h00;
        #1 check("t5_start_cipher_ready", cipher_ready, 0);
        @(negedge clk);
        start = 1'b0; cipher_valid = 1'b0;
        check("t5_dropped_valid", plain_valid, 0);
        check("t5_key_ready_low", key_ready, 0);
        check("t5_count_clear", byte_count, 0);
        wait_ready("t5_rekey_latency");
        cq = '{8'h00, 8'h00};
        eq = '{8'hEB, ks[1]};
        stream(0, 1'b0, 1'b0, "t5_restart");

        // ---------------- 6: async reset during KSA and PRGA_OUT ----------------
        rkey = 24'($urandom);
        do_start(rkey, 8'h0);
        repeat (300) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6a_key_ready", key_ready, 0);
        check("t6a_cipher_ready", cipher_ready, 0);
        check("t6a_plain_out", plain_out, 0);
        check("t6a_plain_valid", plain_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        do_start(rkey, 8'h0);
        wait_ready("t6a_key_ready_after");
        gen_ks(128'(rkey), 3, 6);
        fill_random(4);
        stream(0, 1'b1, 1'b0, "t6a");
        @(negedge clk);
        plain_ready = 1'b1; cipher_valid = 1'b1; cipher_in = 8'($urandom);
        #1 check("t6b_accept", cipher_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("t6b_key_ready", key_ready, 0);
        check("t6b_cipher_ready", cipher_ready, 0);
        check("t6b_plain_out", plain_out, 0);
        check("t6b_plain_valid", plain_valid, 0);
        check("t6b_byte_count", byte_count, 0);
        cipher_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("t6b_key_ready_stays_low", key_ready, 0);
        do_start(rkey, 8'h0);
        wait_ready("t6b_key_ready_after");
        fill_random(4);
        stream(0, 1'b1, 1'b0, "t6b");
        check("t6b_final_count", byte_count, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc4_decrypt_rx.md
Name: rc4_decrypt_rx

Overview:
Receive-side RC4 engine. It takes a key, runs RC4 key scheduling (KSA) on an internal 256-byte S-box, then XORs each incoming ciphertext byte with the next PRGA keystream byte to recover plaintext. It is the decrypting counterpart of the rc4_top transmit path. Both ends share one key, so a byte stream encrypted by rc4_top is restored byte-for-byte.
Streaming uses valid/ready on both sides and a single-entry output register.

Parameters:
KEY_BYTES, 1, key length in bytes (1..16); K[n] = key[8*n+7:8*n].
CNT_W, 16, width of the decrypted-byte counter.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  single-cycle re-key request; key is sampled on the same edge.
key  input  8*KEY_BYTES  RC4 key.
key_ready  output  1  high when KSA is complete and the engine can decrypt.
cipher_in  input  8  ciphertext byte.
cipher_valid  input  1  cipher_in is valid.
cipher_ready  output  1  engine accepts cipher_in this cycle.
plain_out  output  8  plaintext byte.
plain_valid  output  1  plain_out is valid; held until plain_ready.
plain_ready  input  1  downstream accepts plain_out.
byte_count  output  CNT_W  plaintext bytes delivered since the last start.

Behaviour:
- Reset (rst low, async): state=IDLE; key_ready=0, cipher_ready=0, plain_valid=0, plain_out=0, byte_count=0, i=j=0, key register=0. S-box contents are don't-care.
- States: IDLE, INIT, KSA, READY, PRGA_OUT.
- IDLE: waits for start. start latches key, clears i, j, byte_count and plain_valid, then goes to INIT.
- INIT: writes S[i]=i, one entry per cycle, for 256 cycles with i from 0 to 255, then goes to KSA with i=0 and j=0.
- KSA: one iteration per cycle: j' = j + S[i] + K[i mod KEY_BYTES] (mod 256), then swap S[i] and S[j'].
  - Runs 256 cycles, then goes to READY with i=0 and j=0.
  - key_ready rises 513 cycles after the start edge: 1 + 256 + 256.
- READY: key_ready=1. cipher_ready = (state==READY) & (!plain_valid | plain_ready) & !start.
  - A transfer (cipher_valid & cipher_ready) in one cycle does all of the following: latch cipher_in; i' = i+1; j' = j + S[i']; swap S[i'] and S[j']; go to PRGA_OUT.
- PRGA_OUT: t = S[i] + S[j] (mod 256). Load plain_out = c ^ S[t], set plain_valid=1, increment byte_count (wraps to 0 past all-ones), then return to READY.
  - Throughput: 1 byte per 2 cycles.
  - Latency: plain_valid is high 2 cycles after the accepting edge.
- Output handshake: when plain_valid & plain_ready, plain_valid clears unless a new byte loads in that same cycle.
  - plain_out and plain_valid must stay stable while plain_ready is low.
  - Back-pressure reaches cipher_ready in the same cycle.
- start in any state re-keys: it aborts INIT, KSA or PRGA_OUT and drops any pending plain_valid byte. cipher_ready is 0 in the start cycle. key_ready drops on the next edge.
- start together with cipher_valid: start wins and the byte is not accepted.
- cipher_valid outside READY: ignored, cipher_ready=0.
- Reset mid-operation: immediate return to IDLE. key_ready=0 until the next start and a full KSA.
- All index arithmetic is 8-bit modulo 256. The key index uses a separate counter that wraps at KEY_BYTES, so there is no divider.

Decomposition:
- Shared package rc4_pkg, which rc4_top also uses:
  - state enum;
  - constant SBOX_SIZE=256;
  - byte typedef;
  - helper function for the key-byte select.
- One sub-module: rc4_sbox.
  - 256x8 register array.
  - Two combinational read ports plus one swap port, which writes two addresses in one cycle; same-address swap is a no-op.
  - Dual-read/single-swap semantics are needed because KSA and PRGA both need same-cycle read-modify-swap.
- The FSM, counters and output register stay in rc4_decrypt_rx.

Test Plan:
1. Reset then start with key=0 and idle inputs -> key_ready=0 until exactly 513 cycles after the start edge, then 1; cipher_ready=1, plain_valid=0, byte_count=0.
2. KEY_BYTES=3, key=24'h79654B ("Key"); feed ciphertext BB F3 16 E8 D9 40 AF 0A D3 with plain_ready=1 -> plain_out 50 6C 61 69 6E 74 65 78 74 ("Plaintext"), one byte every 2 cycles, byte_count=9.
3. Round trip: rc4_top (password 57248 truncated to 8'hA0) encrypts 05 0A 14 1E 28; the ciphertext goes into this block with key 8'hA0 -> plain_out 05 0A 14 1E 28 in order.
4. Hold plain_ready=0 for 10 cycles after the first output -> plain_out and plain_valid stable, cipher_ready=0, no bytes lost; release -> remaining bytes match the model.
5. Assert start mid-stream, after 3 bytes, together with cipher_valid -> byte not accepted, pending output dropped, key_ready=0; after 513 cycles the keystream restarts from the first keystream byte (EB for key "Key").
6. Deassert rst during KSA and during PRGA_OUT -> all outputs go to reset values asynchronously; a new start gives correct keystream 513 cycles later.
